// File: rtl/ring_counter_param.sv
// ring_counter_param: WIDTH-bit shift counter with two run-time encodings.
// The one-hot ring encoding has WIDTH states. The Johnson (twisted-ring)
// encoding has 2*WIDTH states. The counter steps in either direction, accepts
// a parallel load after checking that the value is legal, and repairs any
// illegal state it finds. It tracks the binary position of cnt in idx and
// emits single-cycle wrap and err pulses.
module ring_counter_param #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  // The value of cnt at index 0: a single LSB in ring mode, all zeros in Johnson mode.
  function automatic logic [WIDTH-1:0] zero_of(input logic m);
    return m ? '0 : ONE;
  endfunction

  // True when v is a contiguous run of ones starting at the LSB (including 0 and all-ones).
  function automatic logic is_lowmask(input logic [WIDTH-1:0] v);
    return ((v & (v + ONE)) == '0);
  endfunction

  function automatic int popcnt(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  // The Johnson patterns are the low masks and the complements of the low masks.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    if (m) return is_lowmask(v) || is_lowmask(~v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Index of a legal value. In Johnson mode, the first half of the sequence
  // fills ones from the LSB, and the second half drains ones from the LSB.
  function automatic logic [IDX_W-1:0] decode(input logic [WIDTH-1:0] v, input logic m);
    logic [IDX_W-1:0] k;
    k = '0;
    if (!m) begin
      for (int i = 0; i < WIDTH; i++) if (v[i]) k = IDX_W'(i);
    end else if (is_lowmask(v)) begin
      k = IDX_W'(popcnt(v));
    end else begin
      k = IDX_W'(2 * WIDTH - popcnt(v));
    end
    return k;
  endfunction

  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                 input logic m, input logic rev);
    logic [WIDTH-1:0] r;
    if (!m) r = rev ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    else    r = rev ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
    return r;
  endfunction

  logic [IDX_W-1:0] last_idx;
  assign last_idx = mode_q ? IDX_W'(2 * WIDTH - 1) : IDX_W'(WIDTH - 1);

  // Next-state selection in priority order: mode change, load, repair, step, hold.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (mode != mode_q) begin
      cnt_d  = zero_of(mode);
      idx_d  = '0;
      mode_d = mode;
    end else if (load) begin
      if (is_legal(load_val, mode_q)) begin
        cnt_d = load_val;
        idx_d = decode(load_val, mode_q);
      end else begin
        cnt_d = zero_of(mode_q);
        idx_d = '0;
        err_d = 1'b1;
      end
    end else if (!is_legal(cnt_q, mode_q)) begin
      cnt_d = zero_of(mode_q);
      idx_d = '0;
      err_d = 1'b1;
    end else if (en) begin
      cnt_d = step_val(cnt_q, mode_q, dir);
      if (!dir) begin
        if (idx_q == last_idx) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = last_idx;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
    end
  end

  // State register; reset re-encodes index 0 in whichever mode is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= zero_of(mode);
      idx_q  <= '0;
      mode_q <= mode;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench for ring_counter_param at WIDTH=8.
module tb_ring_counter_param;
  localparam int W  = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  cnt;
  logic [IW-1:0] idx;
  logic          wrap, err;

  int   total = 0, bad = 0;
  int   inv_total = 0, inv_bad = 0;
  logic chk_on = 1'b0;
  logic enc_mode = 1'b0;

  always #5 clk = ~clk;

  ring_counter_param #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .cnt(cnt), .idx(idx), .wrap(wrap), .err(err)
  );

  // Position of v in the sequence for mode m, found by generating every pattern.
  function automatic int tb_decode(input logic [W-1:0] v, input logic m);
    logic [W:0]   t;
    logic [W-1:0] pat;
    if (!m) begin
      for (int k = 0; k < W; k++) begin
        pat = W'(1) << k;
        if (v === pat) return k;
      end
    end else begin
      for (int k = 0; k < 2 * W; k++) begin
        if (k <= W) begin
          t   = ((W + 1)'(1) << k) - (W + 1)'(1);
          pat = t[W-1:0];
        end else begin
          pat = {W{1'b1}} << (k - W);
        end
        if (v === pat) return k;
      end
    end
    return -1;
  endfunction

  // Every mode input sampled at an edge becomes the encoding of cnt after it.
  always @(posedge clk) enc_mode <= mode;

  // idx must agree with cnt on every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      inv_total++;
      if ($isunknown(idx) || tb_decode(cnt, enc_mode) != int'(idx)) begin
        inv_bad++;
        $display("FAIL idx_consistency t=%0t cnt=%h idx=%0d decoded=%0d", $time, cnt, idx,
                 tb_decode(cnt, enc_mode));
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; en = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0;
    @(posedge clk); #1;
    total++;
    if ({cnt, idx, wrap, err} !== {8'h01, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_ring got cnt=%h idx=%0d wrap=%b err=%b want 01/0/0/0", cnt, idx, wrap, err);
    end
    load = 1'b1; load_val = 8'h40;
    @(posedge clk); #1;
    total++;
    if ({cnt, idx, wrap, err} !== {8'h01, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_over_load got cnt=%h idx=%0d wrap=%b err=%b want 01/0/0/0", cnt, idx, wrap, err);
    end
    load = 1'b0;
    chk_on = 1'b1;
  endtask

  task automatic test_ring_forward();
    logic [7:0] ec [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [3:0] ei [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    logic       ew;
    rst = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ew = (i == 7);
      total++;
      if ({cnt, idx, wrap, err} !== {ec[i], ei[i], ew, 1'b0}) begin
        bad++;
        $display("FAIL ring_fwd step=%0d got cnt=%h idx=%0d wrap=%b err=%b want %h/%0d/%b/0",
                 i, cnt, idx, wrap, err, ec[i], ei[i], ew);
      end
    end
  endtask

  task automatic test_ring_reverse();
    logic       ven [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ec  [4] = '{8'h80, 8'h40, 8'h40, 8'h40};
    logic [3:0] ei  [4] = '{4'd7, 4'd6, 4'd6, 4'd6};
    logic       ew  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = ven[i];
      @(posedge clk); #1;
      total++;
      if ({cnt, idx, wrap, err} !== {ec[i], ei[i], ew[i], 1'b0}) begin
        bad++;
        $display("FAIL ring_rev step=%0d got cnt=%h idx=%0d wrap=%b err=%b want %h/%0d/%b/0",
                 i, cnt, idx, wrap, err, ec[i], ei[i], ew[i]);
      end
    end
  endtask

  task automatic test_johnson();
    logic [7:0] ec [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                            8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [3:0] ei;
    logic       ew;
    rst = 1'b1; mode = 1'b1; en = 1'b0; dir = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cnt, idx, wrap, err} !== {8'h00, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_johnson got cnt=%h idx=%0d wrap=%b err=%b want 00/0/0/0", cnt, idx, wrap, err);
    end
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      ei = 4'(i + 1);
      ew = (i == 15);
      total++;
      if ({cnt, idx, wrap, err} !== {ec[i], ei, ew, 1'b0}) begin
        bad++;
        $display("FAIL johnson_fwd step=%0d got cnt=%h idx=%0d wrap=%b err=%b want %h/%0d/%b/0",
                 i, cnt, idx, wrap, err, ec[i], ei, ew);
      end
    end
    dir = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cnt, idx, wrap, err} !== {8'h80, 4'd15, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL johnson_rev_wrap got cnt=%h idx=%0d wrap=%b err=%b want 80/15/1/0", cnt, idx, wrap, err);
    end
    en = 1'b0;
  endtask

  task automatic test_johnson_load();
    logic [7:0] lv  [4] = '{8'h0F, 8'h05, 8'hFE, 8'h00};
    logic       vld [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ven [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ec  [4] = '{8'h0F, 8'h00, 8'hFE, 8'hFE};
    logic [3:0] ei  [4] = '{4'd4, 4'd0, 4'd9, 4'd9};
    logic       ee  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load = vld[i]; load_val = lv[i]; en = ven[i];
      @(posedge clk); #1;
      total++;
      if ({cnt, idx, wrap, err} !== {ec[i], ei[i], 1'b0, ee[i]}) begin
        bad++;
        $display("FAIL johnson_load step=%0d got cnt=%h idx=%0d wrap=%b err=%b want %h/%0d/0/%b",
                 i, cnt, idx, wrap, err, ec[i], ei[i], ee[i]);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_mode_switch();
    logic       vm  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vld [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] lv  [8] = '{8'h80, 8'h24, 8'h10, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
    logic       ven [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ec  [8] = '{8'h01, 8'h01, 8'h10, 8'h10, 8'h01, 8'h08, 8'h00, 8'h01};
    logic [3:0] ei  [8] = '{4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 4'd3, 4'd0, 4'd1};
    logic       ee  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mode = vm[i]; load = vld[i]; load_val = lv[i]; en = ven[i];
      @(posedge clk); #1;
      total++;
      if ({cnt, idx, wrap, err} !== {ec[i], ei[i], 1'b0, ee[i]}) begin
        bad++;
        $display("FAIL mode_ring_load step=%0d got cnt=%h idx=%0d wrap=%b err=%b want %h/%0d/0/%b",
                 i, cnt, idx, wrap, err, ec[i], ei[i], ee[i]);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       vr  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       vld [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] lv  [7] = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    logic [7:0] ec  [7] = '{8'h01, 8'h20, 8'h01, 8'h02, 8'h80, 8'h01, 8'h02};
    logic [3:0] ei  [7] = '{4'd0, 4'd5, 4'd0, 4'd1, 4'd7, 4'd0, 4'd1};
    logic       ew  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rst = vr[i]; load = vld[i]; load_val = lv[i];
      @(posedge clk); #1;
      total++;
      if ({cnt, idx, wrap, err} !== {ec[i], ei[i], ew[i], 1'b0}) begin
        bad++;
        $display("FAIL back_to_back step=%0d got cnt=%h idx=%0d wrap=%b err=%b want %h/%0d/%b/0",
                 i, cnt, idx, wrap, err, ec[i], ei[i], ew[i]);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ring_forward();
    test_ring_reverse();
    test_johnson();
    test_johnson_load();
    test_mode_switch();
    test_back_to_back();
    @(posedge clk); #1;
    @(negedge clk);
    chk_on = 1'b0;
    #1;
    total += inv_total;
    bad   += inv_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
